// File: rtl/mvu_pe_simd_xnor_acc_pkg.sv
// ---------------------------------------------------------------------------
// mvau_defn
//   Shared definitions for the binary MVAU processing elements.
//   - popw(simd): width needed to hold a popcount of 'simd' one-bit lanes.
//   - POPW:       popcount width for the default lane count.
//   - acc_mode_e: accumulator interpretation (plain popcount sum or +/-1 dot
//                 product), plus the integer encodings used on the PE's
//                 BIPOLAR parameter.
// ---------------------------------------------------------------------------
package mvau_defn;

  function automatic int popw(input int simd);
    return $clog2(simd + 1);
  endfunction

  localparam int SIMD_DEFAULT = 8;
  localparam int POPW         = popw(SIMD_DEFAULT);

  typedef enum logic {
    ACC_UNSIGNED = 1'b0,
    ACC_BIPOLAR  = 1'b1
  } acc_mode_e;

  localparam int BIPOLAR_OFF = 0;
  localparam int BIPOLAR_ON  = 1;

endpackage

// File: rtl/mvu_pe_simd_xnor_acc_popcount.sv
// ---------------------------------------------------------------------------
// mvu_popcount
//   Balanced adder tree counting the ones in an N-bit vector, with an
//   optional output register. A valid bit and a 'last' tag travel alongside
//   the count so the caller sees them aligned with the result.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset (used when PIPE=1)
//     en          pipeline enable; the output register holds when low
//     in_v        input valid
//     in_last     input tag (last fold of a neuron)
//     x           N input bits to count
//     out_v       valid aligned with cnt
//     out_last    tag aligned with cnt
//     cnt         number of ones in x, popw(N) bits wide
// ---------------------------------------------------------------------------
module mvu_popcount
  import mvau_defn::*;
#(
  parameter int N    = 8,
  parameter int PIPE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_v,
  input  logic                 in_last,
  input  logic [N-1:0]         x,
  output logic                 out_v,
  output logic                 out_last,
  output logic [popw(N)-1:0]   cnt
);

  localparam int PW = popw(N);
  localparam int LV = $clog2(N);
  localparam int NP = 1 << LV;

  logic [PW-1:0] tree;

  // Level 0 holds the leaves (padded with zeros up to a power of two);
  // every further level halves the node count, so level LV is the root.
  // All nodes share width PW since no partial sum can exceed N.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int CNT = NP >> l;
    logic [PW-1:0] s [CNT];
    for (genvar i = 0; i < CNT; i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < N) begin : g_bit
          assign s[i] = PW'(x[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_add
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign tree = g_lvl[LV].s[0];

  if (PIPE != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_v    <= 1'b0;
        out_last <= 1'b0;
        cnt      <= '0;
      end else if (en) begin
        out_v    <= in_v;
        out_last <= in_last;
        cnt      <= tree;
      end
    end
  end else begin : g_comb
    // Without the register the control inputs have no function here.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign out_v    = in_v;
    assign out_last = in_last;
    assign cnt      = tree;
  end

endmodule

// File: rtl/mvu_pe_simd_xnor_acc.sv
// ---------------------------------------------------------------------------
// mvu_pe_simd_xnor_acc
//   SIMD-wide binary processing element for the MVAU stream. Each accepted
//   beat XNORs SIMD activation/weight lanes, popcounts them and accumulates
//   the count over the folds of one output neuron. One result per neuron is
//   offered downstream under a valid/ready handshake; backpressure freezes
//   the whole pipe.
//   Parameters: SIMD lanes, TDstI result width, PIPE_POP (register the
//   popcount), BIPOLAR (0 = unsigned count sum, 1 = signed +/-1 dot product).
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     in_v         input beat valid
//     in_rdy       beat can be accepted this cycle
//     in_last      beat is the last fold of its neuron
//     in_act       activation bits, lane i = bit i
//     in_wgt       weight bits, lane i = bit i
//     out_v        result valid
//     out_rdy      downstream accepts the result
//     out          result (two's complement when BIPOLAR=1)
// ---------------------------------------------------------------------------
module mvu_pe_simd_xnor_acc
  import mvau_defn::*;
#(
  parameter int SIMD     = 8,
  parameter int TDstI    = 16,
  parameter int PIPE_POP = 0,
  parameter int BIPOLAR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  output logic              in_rdy,
  input  logic              in_last,
  input  logic [SIMD-1:0]   in_act,
  input  logic [SIMD-1:0]   in_wgt,
  output logic              out_v,
  input  logic              out_rdy,
  output logic [TDstI-1:0]  out
);

  localparam int        PW   = popw(SIMD);
  localparam acc_mode_e MODE = (BIPOLAR != BIPOLAR_OFF) ? ACC_BIPOLAR : ACC_UNSIGNED;

  if (SIMD < 1 || TDstI <= PW) begin : g_param_check
    $error("mvu_pe_simd_xnor_acc: need SIMD >= 1 and TDstI > popcount width");
  end

  logic              en;
  logic              accept;
  logic [SIMD-1:0]   x;
  logic              v1;
  logic              l1;
  logic [PW-1:0]     p;
  logic              v2;
  logic              l2;
  logic [TDstI-1:0]  acc;
  logic [TDstI-1:0]  fcnt;
  logic              first;
  logic [TDstI-1:0]  acc_base;
  logic [TDstI-1:0]  fcnt_base;
  logic [TDstI-1:0]  acc_next;
  logic [TDstI-1:0]  fcnt_next;
  logic [TDstI-1:0]  result;

  // A result stuck at the output freezes every stage at once, so nothing
  // in flight can be overwritten or duplicated.
  assign en     = ~(out_v & ~out_rdy);
  assign in_rdy = en;
  assign accept = in_v & en;

  // S1: data is captured only on accepted beats, so idle-cycle garbage on
  // in_act/in_wgt never enters the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x  <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (en) begin
      v1 <= accept;
      l1 <= accept & in_last;
      if (accept) begin
        x <= in_act ~^ in_wgt;
      end
    end
  end

  mvu_popcount #(
    .N    (SIMD),
    .PIPE (PIPE_POP)
  ) u_pop (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_v     (v1),
    .in_last  (l1),
    .x        (x),
    .out_v    (v2),
    .out_last (l2),
    .cnt      (p)
  );

  // 'first' marks the opening beat of a neuron: the stale total and fold
  // count are ignored then, so neurons run back to back with no idle cycle.
  // In bipolar mode each lane is +1 on match and -1 on mismatch, giving
  // 2*matches - lanes_seen.
  always_comb begin
    acc_base  = first ? '0 : acc;
    fcnt_base = first ? '0 : fcnt;
    acc_next  = acc_base + TDstI'(p);
    fcnt_next = fcnt_base + TDstI'(1);
    result    = acc_next;
    if (MODE == ACC_BIPOLAR) begin
      result = (acc_next << 1) - (TDstI'(SIMD) * fcnt_next);
    end
  end

  // S3: accumulator, fold counter and output register. Whenever en is high
  // the output slot is either empty or being drained, so it is reloaded by a
  // final beat or cleared otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      fcnt  <= '0;
      first <= 1'b1;
      out   <= '0;
      out_v <= 1'b0;
    end else if (en) begin
      if (v2) begin
        acc   <= acc_next;
        fcnt  <= fcnt_next;
        first <= l2;
      end
      if (v2 && l2) begin
        out   <= result;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_simd_xnor_acc.sv
// ---------------------------------------------------------------------------
// tb_mvu_pe_simd_xnor_acc
//   Two instances share clock and reset:
//     dut 0: SIMD=8, TDstI=16, PIPE_POP=0, BIPOLAR=0
//     dut 1: SIMD=8, TDstI=16, PIPE_POP=1, BIPOLAR=1
//   Stimulus pushes the expected result of every completed neuron into a
//   per-instance queue; a monitor pops and compares on each output handshake.
// ---------------------------------------------------------------------------
module tb_mvu_pe_simd_xnor_acc;

  typedef struct {
    logic [15:0] val;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_v    [2];
  logic        in_last [2];
  logic [7:0]  act     [2];
  logic [7:0]  wgt     [2];
  logic        out_rdy [2];
  logic        in_rdy  [2];
  logic        out_v   [2];
  logic [15:0] out_d   [2];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   fresh [2] = '{1'b1, 1'b1};
  int   pres  [2] = '{0, 0};

  localparam logic [7:0] T6_ACT [16] = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E, 8'h55, 8'hAA,
                                         8'hF0, 8'h0F, 8'hC3, 8'h99, 8'h12, 8'h34, 8'hE7, 8'h6B};
  localparam logic [7:0] T6_WGT [16] = '{8'h00, 8'h00, 8'h5A, 8'h3C, 8'h18, 8'h7E, 8'hAA, 8'hAA,
                                         8'hFF, 8'hF3, 8'h3C, 8'h66, 8'h21, 8'h43, 8'h18, 8'hB6};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mvu_pe_simd_xnor_acc #(
    .SIMD(8), .TDstI(16), .PIPE_POP(0), .BIPOLAR(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v[0]), .in_rdy(in_rdy[0]), .in_last(in_last[0]),
    .in_act(act[0]), .in_wgt(wgt[0]),
    .out_v(out_v[0]), .out_rdy(out_rdy[0]), .out(out_d[0])
  );

  mvu_pe_simd_xnor_acc #(
    .SIMD(8), .TDstI(16), .PIPE_POP(1), .BIPOLAR(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v[1]), .in_rdy(in_rdy[1]), .in_last(in_last[1]),
    .in_act(act[1]), .in_wgt(wgt[1]),
    .out_v(out_v[1]), .out_rdy(out_rdy[1]), .out(out_d[1])
  );

  // Reference for a single-fold bipolar neuron with 8 lanes.
  function automatic logic [15:0] bipolarRef(input logic [7:0] a, input logic [7:0] w);
    int         c;
    logic [7:0] m;
    c = 0;
    m = ~(a ^ w);
    for (int i = 0; i < 8; i++) c += int'(m[i]);
    return 16'(2 * c - 8);
  endfunction

  task automatic expectEq(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Presents one beat and holds it until the DUT is ready; the beat is
  // taken at the following rising edge. Completed neurons queue a result.
  task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] w,
                               input logic last, input logic [15:0] expv, input bit chk_lat);
    int   budget;
    exp_t e;
    @(negedge clk);
    in_v[d]    = 1'b1;
    act[d]     = a;
    wgt[d]     = w;
    in_last[d] = last;
    #1;
    budget = 0;
    while (!in_rdy[d] && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_rdy[d]) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout dut=%0d: in_rdy stayed %b, required 1", d, in_rdy[d]);
    end else if (last) begin
      e.val     = expv;
      e.acc_cyc = cyc;
      e.chk_lat = chk_lat;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Drops in_v and drives junk data, which the DUT must ignore.
  task automatic idle(input int d);
    @(negedge clk);
    in_v[d]    = 1'b0;
    act[d]     = 8'($urandom);
    wgt[d]     = 8'($urandom);
    in_last[d] = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending %0d/%0d results, required 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic checkOutput(input int d);
    exp_t e;
    bit   empty;
    int   lat_exp;
    if (!rst_n || !out_v[d]) begin
      fresh[d] = 1'b1;
      return;
    end
    if (fresh[d]) begin
      pres[d]  = cyc;
      fresh[d] = 1'b0;
    end
    if (out_rdy[d]) begin
      fresh[d] = 1'b1;
      empty = 1'b0;
      if (d == 0) begin
        if (q0.size() == 0) empty = 1'b1;
        else e = q0.pop_front();
      end else begin
        if (q1.size() == 0) empty = 1'b1;
        else e = q1.pop_front();
      end
      total++;
      if (empty) begin
        bad++;
        $display("[TB] FAIL unexpected_result dut=%0d: got %h, none expected", d, out_d[d]);
      end else begin
        if (out_d[d] !== e.val) begin
          bad++;
          $display("[TB] FAIL result dut=%0d: got %h expected %h", d, out_d[d], e.val);
        end
        if (e.chk_lat) begin
          lat_exp = (d == 0) ? 2 : 3;
          total++;
          if (pres[d] - e.acc_cyc != lat_exp) begin
            bad++;
            $display("[TB] FAIL latency dut=%0d: got %0d expected %0d", d, pres[d] - e.acc_cyc, lat_exp);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_v[d]    = 1'b0;
      in_last[d] = 1'b0;
      act[d]     = 8'h00;
      wgt[d]     = 8'h00;
      out_rdy[d] = 1'b1;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expectEq("reset_out_v_a", 16'(out_v[0]), 16'h0);
    expectEq("reset_out_a", out_d[0], 16'h0);
    expectEq("reset_in_rdy_a", 16'(in_rdy[0]), 16'h1);
    expectEq("reset_out_v_b", 16'(out_v[1]), 16'h0);
    expectEq("reset_out_b", out_d[1], 16'h0);
    expectEq("reset_in_rdy_b", 16'(in_rdy[1]), 16'h1);
    rst_n = 1'b1;

    // T1: single-fold neuron, xnor(FF,F0)=F0 -> 4
    applyStimulus(0, 8'hFF, 8'hF0, 1'b1, 16'd4, 1'b1);
    idle(0);
    drain();

    // T2: three folds 8 + 0 + 5 = 13
    applyStimulus(0, 8'hAA, 8'hAA, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'h0F, 8'hF0, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'h07, 8'h00, 1'b1, 16'd13, 1'b1);
    idle(0);
    drain();

    // Back-to-back two-fold neurons: 8 + 0 = 8, then 8 + 7 = 15
    applyStimulus(0, 8'hFF, 8'hFF, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'h00, 8'hFF, 1'b1, 16'd8, 1'b1);
    applyStimulus(0, 8'h3C, 8'h3C, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'h01, 8'h00, 1'b1, 16'd15, 1'b1);
    idle(0);
    drain();

    // T4: downstream stalls five cycles while four single-fold beats arrive
    @(posedge clk);
    #1 out_rdy[0] = 1'b0;
    fork
      begin
        applyStimulus(0, 8'hFF, 8'hFE, 1'b1, 16'd7, 1'b0);
        applyStimulus(0, 8'h00, 8'h00, 1'b1, 16'd8, 1'b0);
        applyStimulus(0, 8'hFF, 8'h00, 1'b1, 16'd0, 1'b0);
        applyStimulus(0, 8'h0F, 8'h00, 1'b1, 16'd4, 1'b0);
        idle(0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        expectEq("stall_in_rdy", 16'(in_rdy[0]), 16'h0);
        expectEq("stall_out_v", 16'(out_v[0]), 16'h1);
        repeat (2) @(posedge clk);
        #1 out_rdy[0] = 1'b1;
      end
    join
    drain();

    // T5: reset after two of three folds; partial sum must vanish
    applyStimulus(0, 8'hFF, 8'hFF, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'hFF, 8'hFF, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    in_v[0] = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    expectEq("midreset_out_v", 16'(out_v[0]), 16'h0);
    expectEq("midreset_out", out_d[0], 16'h0);
    expectEq("midreset_in_rdy", 16'(in_rdy[0]), 16'h1);
    rst_n = 1'b1;
    applyStimulus(0, 8'hAA, 8'h55, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'h01, 8'h01, 1'b0, 16'd0, 1'b0);
    applyStimulus(0, 8'hF0, 8'hF0, 1'b1, 16'd16, 1'b1);
    idle(0);
    drain();

    // T3: bipolar, two folds: 8,2 -> 4; then all mismatch -> -16
    applyStimulus(1, 8'hFF, 8'hFF, 1'b0, 16'd0, 1'b0);
    applyStimulus(1, 8'h3F, 8'h00, 1'b1, 16'd4, 1'b1);
    applyStimulus(1, 8'hFF, 8'h00, 1'b0, 16'd0, 1'b0);
    applyStimulus(1, 8'h0F, 8'hF0, 1'b1, 16'hFFF0, 1'b1);
    idle(1);
    drain();

    // T6: registered popcount, sixteen back-to-back single-fold beats
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, T6_ACT[i], T6_WGT[i], 1'b1, bipolarRef(T6_ACT[i], T6_WGT[i]), 1'b1);
    end
    idle(1);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
